// File: rtl/char_fifo_arbiter.sv
// Ring buffer arbiter sharing one single-port character RAM between UART RX writes and Morse reads.
// Build option CHAR_FIFO_OVERWRITE_OLDEST_EN: a write while full replaces the oldest character.
module char_fifo_arbiter #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8
) (
  input  logic              clk_24,
  input  logic              rst,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_req,
  output logic [6:0]        rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overrun,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_wre,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR      = 2'd1,
    RD_ADDR = 2'd2,
    RD_WAIT = 2'd3
  } state_t;

  localparam logic GRANT_RD = 1'b0;
  localparam logic GRANT_WR = 1'b1;
  localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};

  state_t              state;
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   rd_ptr;
  logic                pending;
  logic [DATA_W-1:0]   pend_data;
  logic                last_grant;
  logic                want_wr;
  logic                want_rd;
  logic                grant_wr;
  logic                grant_rd;
  logic                unused_dout_hi;

  assign full           = (count == DEPTH_CNT);
  assign empty          = (count == '0);
  assign state_dbg      = state;
  assign unused_dout_hi = ^ram_dout[DATA_W-1:7];

  // Round robin only decides ties; a lone candidate wins without moving last_grant.
  assign want_wr  = pending;
  assign want_rd  = rd_req && !empty;
  assign grant_wr = (state == IDLE) && want_wr && (!want_rd || last_grant == GRANT_RD);
  assign grant_rd = (state == IDLE) && want_rd && (!want_wr || last_grant == GRANT_WR);

  always_ff @(posedge clk_24 or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      pending    <= 1'b0;
      pend_data  <= '0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      ram_wre    <= 1'b0;
      ram_addr   <= '0;
      ram_din    <= '0;
      overrun    <= 1'b0;
      last_grant <= GRANT_RD;
    end else begin
      rd_valid <= 1'b0;

      // The pending slot frees up in the same cycle it is granted, so a new strobe then is kept.
      if (wr_req) begin
        if (pending && !grant_wr) begin
          overrun <= 1'b1;
        end else begin
          pending   <= 1'b1;
          pend_data <= wr_data;
        end
      end else if (grant_wr) begin
        pending <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (grant_wr) begin
            ram_addr <= wr_ptr;
            ram_din  <= pend_data;
            state    <= WR;
            if (want_rd) last_grant <= GRANT_WR;
            if (full) begin
              overrun <= 1'b1;
`ifdef CHAR_FIFO_OVERWRITE_OLDEST_EN
              ram_wre <= 1'b1;
`else
              ram_wre <= 1'b0;
`endif
            end else begin
              ram_wre <= 1'b1;
            end
          end else if (grant_rd) begin
            ram_addr <= rd_ptr;
            ram_wre  <= 1'b0;
            state    <= RD_ADDR;
            if (want_wr) last_grant <= GRANT_RD;
          end
        end
        WR: begin
          ram_wre <= 1'b0;
          state   <= IDLE;
          if (ram_wre) begin
            wr_ptr <= wr_ptr + 1'b1;
`ifdef CHAR_FIFO_OVERWRITE_OLDEST_EN
            if (full) rd_ptr <= rd_ptr + 1'b1;
            else      count  <= count + 1'b1;
`else
            count <= count + 1'b1;
`endif
          end
        end
        RD_ADDR: begin
          state <= RD_WAIT;
        end
        RD_WAIT: begin
          rd_data  <= ram_dout[6:0];
          rd_valid <= 1'b1;
          rd_ptr   <= rd_ptr + 1'b1;
          count    <= count - 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_char_fifo_arbiter.sv
// Bench for char_fifo_arbiter: RAM model, vector table, corner sequences and random ops vs a queue model.
module tb_char_fifo_arbiter;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 2**ADDR_W;

  logic              clk_24;
  logic              rst;
  logic              wr_req;
  logic [DATA_W-1:0] wr_data;
  logic              rd_req;
  logic [6:0]        rd_data;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overrun;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic              ram_wre;
  logic [DATA_W-1:0] ram_dout;
  logic [1:0]        state_dbg;

  char_fifo_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_24(clk_24), .rst(rst), .wr_req(wr_req), .wr_data(wr_data), .rd_req(rd_req),
    .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty), .count(count),
    .overrun(overrun), .ram_addr(ram_addr), .ram_din(ram_din), .ram_wre(ram_wre),
    .ram_dout(ram_dout), .state_dbg(state_dbg)
  );

  // clock / reset / RAM model
  initial clk_24 = 1'b0;
  always #5 clk_24 = ~clk_24;

  logic [DATA_W-1:0] mem [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    ram_dout = '0;
  end
  always @(posedge clk_24) begin
    if (ram_wre) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic model_ovr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic void model_write(input logic [DATA_W-1:0] d);
    if (exp_q.size() < DEPTH) begin
      exp_q.push_back(d);
    end else begin
      model_ovr = 1'b1;
`ifdef CHAR_FIFO_OVERWRITE_OLDEST_EN
      void'(exp_q.pop_front());
      exp_q.push_back(d);
`endif
    end
  endfunction

  task automatic check_state(input string tag);
    check({tag, "_count"}, 32'(count), 32'(exp_q.size()));
    check({tag, "_full"}, 32'(full), 32'(exp_q.size() == DEPTH));
    check({tag, "_empty"}, 32'(empty), 32'(exp_q.size() == 0));
    check({tag, "_overrun"}, 32'(overrun), 32'(model_ovr));
  endtask

  // driver tasks; each returns 1 time unit after a rising edge
  task automatic do_reset();
    rst = 1'b1;
    wr_req = 1'b0;
    rd_req = 1'b0;
    wr_data = '0;
    repeat (2) @(posedge clk_24);
    #1 rst = 1'b0;
    exp_q.delete();
    model_ovr = 1'b0;
  endtask

  task automatic wr_byte(input logic [DATA_W-1:0] d);
    wr_req = 1'b1;
    wr_data = d;
    @(posedge clk_24);
    #1 wr_req = 1'b0;
    repeat (2) @(posedge clk_24);
    #1;
    model_write(d);
    check_state("wr");
  endtask

  task automatic rd_byte(output logic [6:0] got_d);
    logic got;
    logic [DATA_W-1:0] e;
    got = 1'b0;
    got_d = '0;
    rd_req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk_24);
      #1;
      if (rd_valid) begin
        got = 1'b1;
        break;
      end
    end
    rd_req = 1'b0;
    check("rd_valid_seen", 32'(got), 32'd1);
    if (got) begin
      got_d = rd_data;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rd_data_model", 32'(rd_data), 32'(e[6:0]));
      end
      check_state("rd");
    end
  endtask

  typedef struct {
    logic       is_wr;
    logic [7:0] data;
    logic [6:0] exp_rd;
    int         exp_cnt;
  } vec_t;

  vec_t tbl[10];
  int grants[$];
  logic [6:0] rv;
  logic bad;
  logic seen;

  initial begin
    tbl[0] = '{1'b1, 8'h41, 7'h00, 1};
    tbl[1] = '{1'b1, 8'hC2, 7'h00, 2};
    tbl[2] = '{1'b0, 8'h00, 7'h41, 1};
    tbl[3] = '{1'b0, 8'h00, 7'h42, 0};
    tbl[4] = '{1'b1, 8'h7F, 7'h00, 1};
    tbl[5] = '{1'b1, 8'h00, 7'h00, 2};
    tbl[6] = '{1'b0, 8'h00, 7'h7F, 1};
    tbl[7] = '{1'b1, 8'hD5, 7'h00, 2};
    tbl[8] = '{1'b0, 8'h00, 7'h00, 1};
    tbl[9] = '{1'b0, 8'h00, 7'h55, 0};

    // reset values and first write/read with exact timing
    do_reset();
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_ram_wre", 32'(ram_wre), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);

    wr_req = 1'b1; wr_data = 8'h41;
    @(posedge clk_24); #1 wr_req = 1'b0;
    @(posedge clk_24); #1;
    check("w1_ram_wre", 32'(ram_wre), 32'd1);
    check("w1_ram_addr", 32'(ram_addr), 32'd0);
    check("w1_ram_din", 32'(ram_din), 32'h41);
    @(posedge clk_24); #1;
    check("w1_ram_wre_drop", 32'(ram_wre), 32'd0);
    check("w1_count", 32'(count), 32'd1);
    check("w1_empty", 32'(empty), 32'd0);
    rd_req = 1'b1;
    @(posedge clk_24); #1;
    check("r1_grant_addr", 32'(ram_addr), 32'd0);
    @(posedge clk_24); #1;
    check("r1_not_yet", 32'(rd_valid), 32'd0);
    @(posedge clk_24); #1;
    rd_req = 1'b0;
    check("r1_valid", 32'(rd_valid), 32'd1);
    check("r1_data", 32'(rd_data), 32'h41);
    check("r1_count", 32'(count), 32'd0);
    check("r1_empty", 32'(empty), 32'd1);
    @(posedge clk_24); #1;
    check("r1_valid_pulse", 32'(rd_valid), 32'd0);

    // vector table
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].is_wr) begin
        wr_byte(tbl[i].data);
      end else begin
        rd_byte(rv);
        check($sformatf("tbl%0d_rd", i), 32'(rv), 32'(tbl[i].exp_rd));
      end
      check($sformatf("tbl%0d_cnt", i), 32'(count), 32'(tbl[i].exp_cnt));
      check($sformatf("tbl%0d_ovr", i), 32'(overrun), 32'd0);
    end

    // read held on empty buffer is never granted
    do_reset();
    rd_req = 1'b1;
    bad = 1'b0;
    repeat (20) begin
      @(posedge clk_24); #1;
      if (rd_valid || ram_wre || state_dbg != 2'd0) bad = 1'b1;
    end
    check("empty_hold_idle", 32'(bad), 32'd0);
    wr_byte(8'h53);
    rd_byte(rv);
    check("empty_hold_rd", 32'(rv), 32'h53);

    // tied requests alternate W,R,W,R
    do_reset();
    wr_byte(8'h10); wr_byte(8'h11); wr_byte(8'h12);
    wr_req = 1'b1; wr_data = 8'h20;
    @(posedge clk_24); #1 wr_req = 1'b0;
    rd_req = 1'b1;
    grants.delete();
    for (int i = 0; i < 40 && grants.size() < 4; i++) begin
      @(posedge clk_24); #1;
      wr_req = 1'b0;
      if (state_dbg == 2'd1) begin
        grants.push_back(1);
        if (grants.size() < 4) begin
          wr_req = 1'b1;
          wr_data = 8'h21 + 8'(i);
        end
      end else if (state_dbg == 2'd2) begin
        grants.push_back(2);
      end
    end
    rd_req = 1'b0;
    wr_req = 1'b0;
    check("alt_grant_count", 32'(grants.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < grants.size()) check($sformatf("alt_grant%0d", i), 32'(grants[i]), (i % 2 == 0) ? 32'd1 : 32'd2);
    end
    repeat (4) @(posedge clk_24);
    #1;

    // two strobes while a read is in flight: second byte lost
    do_reset();
    wr_byte(8'h31);
    rd_req = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk_24); #1;
      if (state_dbg == 2'd2) begin
        seen = 1'b1;
        break;
      end
    end
    check("ovr_rd_addr_seen", 32'(seen), 32'd1);
    wr_req = 1'b1; wr_data = 8'h32;
    @(posedge clk_24); #1 wr_data = 8'h33;
    @(posedge clk_24); #1 wr_req = 1'b0;
    rd_req = 1'b0;
    check("ovr_rd_valid", 32'(rd_valid), 32'd1);
    check("ovr_rd_data", 32'(rd_data), 32'h31);
    check("ovr_flag", 32'(overrun), 32'd1);
    void'(exp_q.pop_front());
    model_ovr = 1'b1;
    repeat (2) @(posedge clk_24);
    #1;
    exp_q.push_back(8'h32);
    check_state("ovr_pending");
    rd_byte(rv);
    check("ovr_kept_first", 32'(rv), 32'h32);
    wr_byte(8'h34);
    rd_byte(rv);
    check("ovr_sticky", 32'(overrun), 32'd1);
    do_reset();
    check("ovr_cleared", 32'(overrun), 32'd0);

    // fill, then write while full
    for (int i = 0; i < DEPTH; i++) wr_byte(8'h30 + 8'(i));
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(count), 32'(DEPTH));
    wr_req = 1'b1; wr_data = 8'h5A;
    @(posedge clk_24); #1 wr_req = 1'b0;
    @(posedge clk_24); #1;
    check("full_wr_addr_wrap", 32'(ram_addr), 32'd0);
`ifdef CHAR_FIFO_OVERWRITE_OLDEST_EN
    check("full_wr_wre", 32'(ram_wre), 32'd1);
`else
    check("full_wr_wre", 32'(ram_wre), 32'd0);
`endif
    @(posedge clk_24); #1;
    model_write(8'h5A);
    check_state("full_wr");
    check("full_wr_ovr", 32'(overrun), 32'd1);
    rd_byte(rv);
`ifdef CHAR_FIFO_OVERWRITE_OLDEST_EN
    check("full_next_rd", 32'(rv), 32'h31);
`else
    check("full_next_rd", 32'(rv), 32'h30);
`endif
    while (exp_q.size() > 0) rd_byte(rv);
`ifdef CHAR_FIFO_OVERWRITE_OLDEST_EN
    check("full_last_rd", 32'(rv), 32'h5A);
`else
    check("full_last_rd", 32'(rv), 32'h37);
`endif

    // asynchronous reset during RD_WAIT
    do_reset();
    wr_byte(8'h44);
    rd_req = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk_24); #1;
      if (state_dbg == 2'd3) begin
        seen = 1'b1;
        break;
      end
    end
    check("arst_rd_wait_seen", 32'(seen), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_rd_valid", 32'(rd_valid), 32'd0);
    check("arst_count", 32'(count), 32'd0);
    check("arst_state", 32'(state_dbg), 32'd0);
    check("arst_ram_wre", 32'(ram_wre), 32'd0);
    rd_req = 1'b0;
    bad = 1'b0;
    repeat (3) begin
      @(posedge clk_24); #1;
      if (rd_valid) bad = 1'b1;
    end
    check("arst_no_valid", 32'(bad), 32'd0);
    rst = 1'b0;
    exp_q.delete();
    model_ovr = 1'b0;

    // random operations against the queue model
    for (int n = 0; n < 300; n++) begin
      if (exp_q.size() > 0 && $urandom_range(0, 99) < 45) rd_byte(rv);
      else wr_byte(8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 2)) @(posedge clk_24);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
